// File: rtl/wta_spike_capture.sv
// Winner-take-all spike capture: one first-edge record per gamma cycle,
// buffered in a small FIFO behind a valid/ready interface.
module wta_spike_capture #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int NUM_INPUTS        = 16,
    parameter int FIFO_DEPTH        = 4,
    localparam int IW = $clog2(NUM_INPUTS),
    localparam int TW = $clog2(GAMMA_CYCLE_WIDTH),
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  aclk,
    input  logic                  rst,
    input  logic [NUM_INPUTS-1:0] spikes_in,
    output logic [TW-1:0]         gamma_phase,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IW-1:0]         out_winner,
    output logic [TW-1:0]         out_time,
    output logic                  out_multi,
    output logic                  out_none,
    output logic [LW-1:0]         fifo_level,
    output logic [7:0]            overflow_count
);

    localparam int PW = $clog2(FIFO_DEPTH);

    if (GAMMA_CYCLE_WIDTH < 2 || NUM_INPUTS < 2 || PULSE_WIDTH < 1) begin : g_bad_param
        $error("wta_spike_capture: illegal parameter value");
    end

    typedef enum logic {IDLE, CAPTURED} state_t;

    typedef struct packed {
        logic [IW-1:0] winner;
        logic [TW-1:0] tstamp;
        logic          multi;
        logic          none;
    } rec_t;

    logic [TW-1:0]         phase_q, phase_d;
    logic [NUM_INPUTS-1:0] prev_q;
    logic [NUM_INPUTS-1:0] rise;
    state_t                state_q, state_d;
    logic [IW-1:0]         win_q, win_d;
    logic [TW-1:0]         tim_q, tim_d;
    logic                  multi_q, multi_d;
    logic [IW-1:0]         lo_idx;
    logic                  multi_now;
    logic                  close;
    rec_t                  rec;

    rec_t                  mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [7:0]            ovf_q, ovf_d;
    logic                  pop, full, wr_en, drop;
    rec_t                  head;

    assign rise      = spikes_in & ~prev_q;
    assign multi_now = |(rise & (rise - NUM_INPUTS'(1)));
    assign close     = (phase_q == TW'(GAMMA_CYCLE_WIDTH - 1));
    assign phase_d   = close ? '0 : phase_q + 1'b1;

    // Scan downward so the lowest set index is the one that sticks.
    always_comb begin
        lo_idx = '0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (rise[i]) lo_idx = IW'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        tim_d      = tim_q;
        multi_d    = multi_q;
        rec        = '0;
        rec.none   = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (|rise) begin
                    state_d = CAPTURED;
                    win_d   = lo_idx;
                    tim_d   = phase_q;
                    multi_d = multi_now;
                end
            end
            CAPTURED: ;
            default: state_d = IDLE;
        endcase
        if (close) begin
            if (state_q == CAPTURED) begin
                rec = '{winner: win_q, tstamp: tim_q, multi: multi_q, none: 1'b0};
            end else if (|rise) begin
                rec = '{winner: lo_idx, tstamp: phase_q, multi: multi_now, none: 1'b0};
            end
            state_d = IDLE;
        end
    end

    assign pop   = (level_q != '0) && out_ready;
    assign full  = (level_q == LW'(FIFO_DEPTH));
    assign wr_en = close && (!full || pop);
    assign drop  = close && full && !pop;

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        unique case ({wr_en, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        ovf_d = (drop && ovf_q != 8'hFF) ? ovf_q + 1'b1 : ovf_q;
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            phase_q  <= '0;
            prev_q   <= '0;
            state_q  <= IDLE;
            win_q    <= '0;
            tim_q    <= '0;
            multi_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= '0;
        end else begin
            phase_q  <= phase_d;
            prev_q   <= spikes_in;
            state_q  <= state_d;
            win_q    <= win_d;
            tim_q    <= tim_d;
            multi_q  <= multi_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr_q] <= rec;
    end

    assign head           = mem[rd_ptr_q];
    assign out_valid      = (level_q != '0);
    assign out_winner     = out_valid ? head.winner : '0;
    assign out_time       = out_valid ? head.tstamp : '0;
    assign out_multi      = out_valid & head.multi;
    assign out_none       = out_valid & head.none;
    assign fifo_level     = level_q;
    assign overflow_count = ovf_q;
    assign gamma_phase    = phase_q;

endmodule

// File: tb/tb_wta_spike_capture.sv
// Randomised and directed bench for wta_spike_capture with a
// queue-based reference model and a decoupled output monitor.
module tb_wta_spike_capture;

    localparam int G = 16;
    localparam int N = 16;
    localparam int D = 4;

    logic         aclk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] spikes_in = '0;
    logic         out_ready = 1'b0;
    logic [3:0]   gamma_phase;
    logic         out_valid;
    logic [3:0]   out_winner;
    logic [3:0]   out_time;
    logic         out_multi;
    logic         out_none;
    logic [2:0]   fifo_level;
    logic [7:0]   overflow_count;

    wta_spike_capture #(
        .GAMMA_CYCLE_WIDTH(G),
        .PULSE_WIDTH(8),
        .NUM_INPUTS(N),
        .FIFO_DEPTH(D)
    ) dut (
        .aclk(aclk),
        .rst(rst),
        .spikes_in(spikes_in),
        .gamma_phase(gamma_phase),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_winner(out_winner),
        .out_time(out_time),
        .out_multi(out_multi),
        .out_none(out_none),
        .fifo_level(fifo_level),
        .overflow_count(overflow_count)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int w;
        int t;
        bit m;
        bit n;
    } rec_t;

    rec_t         exp_q[$];
    int           ph_m, lvl_m, ovf_m;
    bit           cap_m;
    rec_t         lat_m;
    logic [N-1:0] prev_m;
    int           cur_ph, cur_lvl, cur_ovf;
    int           vectors = 0;
    int           errors = 0;

    task automatic chk(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        ph_m = 0;
        lvl_m = 0;
        ovf_m = 0;
        cap_m = 0;
        prev_m = '0;
        exp_q.delete();
    endtask

    // Predicts what the coming clock edge does, from the applied inputs.
    task automatic model_edge();
        logic [N-1:0] r;
        rec_t rec;
        bit found;
        r = spikes_in & ~prev_m;
        prev_m = spikes_in;
        if (!cap_m && r != '0) begin
            cap_m = 1;
            found = 0;
            for (int i = 0; i < N; i++) begin
                if (!found && r[i]) begin
                    lat_m.w = i;
                    found = 1;
                end
            end
            lat_m.t = ph_m;
            lat_m.m = ($countones(r) > 1);
            lat_m.n = 0;
        end
        if (lvl_m > 0 && out_ready) lvl_m--;
        if (ph_m == G - 1) begin
            rec = cap_m ? lat_m : '{0, 0, 1'b0, 1'b1};
            if (lvl_m == D) begin
                if (ovf_m < 255) ovf_m++;
            end else begin
                exp_q.push_back(rec);
                lvl_m++;
            end
            cap_m = 0;
        end
        ph_m = (ph_m + 1) % G;
    endtask

    task automatic step(input logic [N-1:0] spk, input bit rdy);
        @(negedge aclk);
        rst = 1'b0;
        cur_ph = ph_m;
        cur_lvl = lvl_m;
        cur_ovf = ovf_m;
        spikes_in = spk;
        out_ready = rdy;
        model_edge();
    endtask

    // rmode: 0 never ready, 1 always ready, 2 ready only on the closing phase
    task automatic run_gamma(input logic [N-1:0] m1, input int s1, input int e1,
                             input logic [N-1:0] m2, input int s2, input int e2,
                             input int rmode);
        logic [N-1:0] spk;
        bit rdy;
        for (int p = 0; p < G; p++) begin
            spk = '0;
            if (p >= s1 && p <= e1) spk |= m1;
            if (p >= s2 && p <= e2) spk |= m2;
            rdy = (rmode == 1) || (rmode == 2 && p == G - 1);
            step(spk, rdy);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_phase"}, int'(gamma_phase), 0);
        chk({tag, "_valid"}, int'(out_valid), 0);
        chk({tag, "_level"}, int'(fifo_level), 0);
        chk({tag, "_ovf"}, int'(overflow_count), 0);
        chk({tag, "_fields"}, int'({out_winner, out_time, out_multi, out_none}), 0);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        rst = 1'b1;
        spikes_in = '0;
        out_ready = 1'b0;
        model_reset();
        #1;
        check_zero("rst");
        repeat (2) @(negedge aclk);
    endtask

    initial begin
        forever begin
            @(negedge aclk);
            #4;
            if (!rst) begin
                chk("phase", int'(gamma_phase), cur_ph);
                chk("level", int'(fifo_level), cur_lvl);
                chk("overflow", int'(overflow_count), cur_ovf);
                chk("valid", int'(out_valid), int'(cur_lvl != 0));
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("scoreboard_empty", 1, 0);
                    end else begin
                        chk("winner", int'(out_winner), exp_q[0].w);
                        chk("time", int'(out_time), exp_q[0].t);
                        chk("multi", int'(out_multi), int'(exp_q[0].m));
                        chk("none", int'(out_none), int'(exp_q[0].n));
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [N-1:0] spk;
        model_reset();
        #3;
        check_zero("init");

        run_gamma(16'h0020, 3, 10, '0, 0, -1, 1);
        run_gamma(16'h0204, 7, 9, 16'h0001, 10, 12, 1);
        repeat (3) run_gamma('0, 0, -1, '0, 0, -1, 1);

        run_gamma(16'h0010, 15, 15, '0, 0, -1, 1);
        run_gamma(16'h0010, 0, 2, 16'h0040, 0, 3, 1);
        run_gamma(16'h0002, 10, 15, '0, 0, -1, 1);
        run_gamma(16'h0002, 0, 4, '0, 0, -1, 1);
        run_gamma('0, 0, -1, '0, 0, -1, 1);

        repeat (6) run_gamma(16'h0008, 1, 2, '0, 0, -1, 0);
        chk("ovf_after_6", int'(overflow_count), 2);
        run_gamma('0, 0, -1, '0, 0, -1, 1);

        repeat (5) run_gamma(16'h0100, 5, 6, '0, 0, -1, 0);
        run_gamma(16'h0080, 4, 6, '0, 0, -1, 2);
        run_gamma('0, 0, -1, '0, 0, -1, 1);
        run_gamma('0, 0, -1, '0, 0, -1, 1);

        run_gamma(16'h0400, 2, 4, '0, 0, -1, 1);
        run_gamma(16'h0800, 2, 4, '0, 0, -1, 1);
        for (int p = 0; p < 8; p++) step((p >= 2 && p <= 4) ? 16'h0200 : 16'h0000, 1'b1);
        do_reset();
        run_gamma(16'h0080, 5, 8, '0, 0, -1, 1);
        run_gamma('0, 0, -1, '0, 0, -1, 1);

        repeat (262) run_gamma(16'h1000, 9, 9, '0, 0, -1, 0);
        chk("ovf_saturated", int'(overflow_count), 255);
        run_gamma('0, 0, -1, '0, 0, -1, 1);

        spk = '0;
        for (int c = 0; c < 40 * G; c++) begin
            if ($urandom_range(0, 3) == 0) spk = N'($urandom & $urandom & $urandom);
            step(spk, $urandom_range(0, 3) != 0);
        end
        repeat (2) run_gamma('0, 0, -1, '0, 0, -1, 1);

        @(negedge aclk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
